pe_ld_req_buffer: RTL

//  Per-PE load-request buffer between one PE's load unit and one ld_* lane of the

---
 rtl/pe_ld_req_buffer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pe_ld_req_buffer.sv
// Per-PE load-request buffer.
// Queues PE load addresses towards one interconnect ld_* lane and holds
// ld_req/ld_addr stable until granted. In-order load data returns are
// collected in a response FIFO. Requests are credit-limited so that returning
// data always has a free response slot.
module pe_ld_req_buffer #(
    parameter int GLOBAL_MEM_ADDR_L = 16,
    parameter int DATA_L            = 32,
    parameter int REQ_DEPTH         = 4,
    parameter int RESP_DEPTH        = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [GLOBAL_MEM_ADDR_L-1:0]  pe_ld_addr,
    input  logic                          pe_ld_vld,
    output logic                          pe_ld_rdy,
    output logic [DATA_L-1:0]             pe_data,
    output logic                          pe_data_vld,
    input  logic                          pe_data_rdy,
    output logic [GLOBAL_MEM_ADDR_L-1:0]  ld_addr,
    output logic                          ld_req,
    input  logic                          ld_gnt,
    input  logic [DATA_L-1:0]             ld_data,
    input  logic                          ld_data_vld,
    output logic [$clog2(RESP_DEPTH):0]   n_inflight,
    output logic                          err_unexp_rsp
);

    localparam int AW = $clog2(REQ_DEPTH);
    localparam int RW = $clog2(RESP_DEPTH);
    localparam int CW = RW + 1;

    localparam logic [AW:0]   REQ_ONE   = 1;
    localparam logic [RW:0]   RESP_ONE  = 1;
    localparam logic [CW-1:0] CNT_ONE   = 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(RESP_DEPTH);
    localparam logic [CW:0]   CREDIT_LIM = (CW + 1)'(RESP_DEPTH);

    // Request FIFO storage and pointers (extra MSB separates full from empty)
    logic [GLOBAL_MEM_ADDR_L-1:0] req_mem [REQ_DEPTH];
    logic [AW:0]                  req_wr_ptr;
    logic [AW:0]                  req_rd_ptr;
    logic                         req_empty;
    logic                         req_full;
    logic                         req_push;
    logic                         req_pop;

    // Response FIFO storage and pointers
    logic [DATA_L-1:0]            resp_mem [RESP_DEPTH];
    logic [RW:0]                  resp_wr_ptr;
    logic [RW:0]                  resp_rd_ptr;
    logic [RW:0]                  resp_count;
    logic                         resp_empty;
    logic                         resp_full;
    logic                         resp_push;
    logic                         resp_pop;

    logic [CW:0]                  credit_sum;
    logic                         credit_ok;
    logic                         rsp_expected;

    assign req_empty = (req_wr_ptr == req_rd_ptr);
    assign req_full  = (req_wr_ptr[AW-1:0] == req_rd_ptr[AW-1:0]) &&
                       (req_wr_ptr[AW] != req_rd_ptr[AW]);

    assign resp_count = resp_wr_ptr - resp_rd_ptr;
    assign resp_empty = (resp_wr_ptr == resp_rd_ptr);
    assign resp_full  = (resp_wr_ptr[RW-1:0] == resp_rd_ptr[RW-1:0]) &&
                        (resp_wr_ptr[RW] != resp_rd_ptr[RW]);

    // A new request may only go out if its data is guaranteed a response slot
    assign credit_sum = {1'b0, n_inflight} + {1'b0, resp_count};
    assign credit_ok  = (credit_sum < CREDIT_LIM);

    assign pe_ld_rdy   = !req_full;
    assign ld_req      = !req_empty && credit_ok;
    assign ld_addr     = req_mem[req_rd_ptr[AW-1:0]];
    assign pe_data_vld = !resp_empty;
    assign pe_data     = resp_mem[resp_rd_ptr[RW-1:0]];

    assign rsp_expected = (n_inflight != '0);
    assign req_push     = pe_ld_vld && pe_ld_rdy;
    assign req_pop      = ld_req && ld_gnt;
    assign resp_push    = ld_data_vld && rsp_expected;
    assign resp_pop     = pe_data_vld && pe_data_rdy;

    // Request address storage; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
        if (req_push) begin
            req_mem[req_wr_ptr[AW-1:0]] <= pe_ld_addr;
        end
    end

    // Request FIFO pointers: push from the PE, pop on a granted request
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_wr_ptr <= '0;
            req_rd_ptr <= '0;
        end else begin
            if (req_push) begin
                req_wr_ptr <= req_wr_ptr + REQ_ONE;
            end
            if (req_pop) begin
                req_rd_ptr <= req_rd_ptr + REQ_ONE;
            end
        end
    end

    // Response data storage; only expected returns are written
    always_ff @(posedge clk) begin
        if (resp_push) begin
            resp_mem[resp_wr_ptr[RW-1:0]] <= ld_data;
        end
    end

    // Response FIFO pointers: push on expected return, pop when the PE consumes
    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_wr_ptr <= '0;
            resp_rd_ptr <= '0;
        end else begin
            if (resp_push) begin
                resp_wr_ptr <= resp_wr_ptr + RESP_ONE;
            end
            if (resp_pop) begin
                resp_rd_ptr <= resp_rd_ptr + RESP_ONE;
            end
        end
    end

    // In-flight counter: grants add one, expected returns remove one, both cancel
    always_ff @(posedge clk) begin
        if (!rst) begin
            n_inflight <= '0;
        end else begin
            case ({req_pop, resp_push})
                2'b10:   n_inflight <= n_inflight + CNT_ONE;
                2'b01:   n_inflight <= n_inflight - CNT_ONE;
                default: n_inflight <= n_inflight;
            endcase
        end
    end

    // Sticky flag for data arriving when nothing was outstanding
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_unexp_rsp <= 1'b0;
        end else if (ld_data_vld && !rsp_expected) begin
            err_unexp_rsp <= 1'b1;
        end
    end

    // Protocol and structural invariants
    a_addr_known: assert property (@(posedge clk) disable iff (!rst)
        ld_req |-> !$isunknown(ld_addr));

    a_inflight_max: assert property (@(posedge clk) disable iff (!rst)
        n_inflight <= CNT_MAX);

    a_addr_stable: assert property (@(posedge clk) disable iff (!rst)
        (ld_req && !ld_gnt) |=> $stable(ld_addr));

    a_resp_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        resp_push |-> !resp_full);

endmodule
